// File: rtl/dds_pkg.sv
// ============================================================================
// Module      : dds_pkg
// Description : Shared state encoding, default timing and helpers for the
//               DDS parallel-port engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
      ST_IOUP = 3'd3,
      ST_GAP  = 3'd4
   } state_e;

   localparam int c_def_num_ch   = 2;
   localparam int c_def_bytes    = 4;
   localparam int c_def_half     = 2;
   localparam int c_def_ioup_len = 2;
   localparam int c_def_cs_gap   = 3;

   function automatic int clog2min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dds_par_engine_arb.sv
// ============================================================================
// Module      : dds_arb
// Description : Fixed-priority (stream over host) request arbiter and mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_arb #(
   parameter int CH_W = 1,
   parameter int DW   = 32
) (
   input  logic            rst,
   input  logic            idle_i,
   input  logic            host_valid_i,
   input  logic            host_wr_i,
   input  logic [CH_W-1:0] host_ch_i,
   input  logic [DW-1:0]   host_data_i,
   input  logic            freq_valid_i,
   input  logic [CH_W-1:0] freq_ch_i,
   input  logic [DW-1:0]   freq_data_i,
   output logic            host_ready_o,
   output logic            freq_ready_o,
   output logic            accept_o,
   output logic [CH_W-1:0] sel_ch_o,
   output logic            sel_wr_o,
   output logic [DW-1:0]   sel_data_o
);

   always_comb begin
      freq_ready_o = idle_i & ~rst & freq_valid_i;
      host_ready_o = idle_i & ~rst & ~freq_valid_i;
      accept_o     = freq_ready_o | (host_ready_o & host_valid_i);
      // Stream frames are always writes.
      if (freq_valid_i) begin
         sel_ch_o   = freq_ch_i;
         sel_wr_o   = 1'b1;
         sel_data_o = freq_data_i;
      end else begin
         sel_ch_o   = host_ch_i;
         sel_wr_o   = host_wr_i;
         sel_data_o = host_data_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dds_par_engine.sv
// ============================================================================
// Module      : dds_par_engine
// Description : Multi-chip DDS parallel-port engine (write/read frames,
//               IO_UPDATE pulse, CS gap) with host and stream request ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_par_engine
   import dds_pkg::*;
#(
   parameter int NUM_CH   = c_def_num_ch,
   parameter int CH_W     = clog2min1(NUM_CH),
   parameter int BYTES    = c_def_bytes,
   parameter int HALF     = c_def_half,
   parameter int IOUP_LEN = c_def_ioup_len,
   parameter int CS_GAP   = c_def_cs_gap
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic               host_wr,
   input  logic [CH_W-1:0]    host_ch,
   input  logic [8*BYTES-1:0] host_data,
   output logic               rsp_valid,
   output logic [8*BYTES-1:0] rsp_data,
   input  logic               freq_valid,
   output logic               freq_ready,
   input  logic [CH_W-1:0]    freq_ch,
   input  logic [8*BYTES-1:0] freq_data,
   output logic               busy,
   output logic               dds_pclk,
   output logic [NUM_CH-1:0]  dds_csn,
   output logic               dds_rwn,
   output logic               dds_read_en,
   output logic               dds_ioup,
   output logic [7:0]         dds_dout,
   input  logic [7:0]         dds_din
);

   localparam int c_dw   = 8 * BYTES;
   localparam int c_tmax = (HALF > IOUP_LEN) ? ((HALF > CS_GAP) ? HALF : CS_GAP)
                                             : ((IOUP_LEN > CS_GAP) ? IOUP_LEN : CS_GAP);
   localparam int c_cw   = clog2min1(c_tmax + 1);
   localparam int c_bw   = clog2min1(BYTES + 1);

   state_e            state_q, state_d;
   logic [c_cw-1:0]   cnt_q, cnt_d;
   logic [c_bw-1:0]   byte_q, byte_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              wr_q, wr_d;
   logic [c_dw-1:0]   shift_q, shift_d;
   logic [c_dw-1:0]   cap_q, cap_d;
   logic [NUM_CH-1:0] csn_q, csn_d;
   logic              pclk_q, pclk_d, rwn_q, rwn_d, rden_q, rden_d, ioup_q, ioup_d;
   logic [7:0]        dout_q, dout_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [c_dw-1:0]   rsp_data_q, rsp_data_d;

   logic              accept_w, sel_wr_w;
   logic [CH_W-1:0]   sel_ch_w;
   logic [c_dw-1:0]   sel_data_w;
   logic [NUM_CH-1:0] hit_w;

   dds_arb #(.CH_W(CH_W), .DW(c_dw)) u_arb (
      .rst          (rst),
      .idle_i       (state_q == ST_IDLE),
      .host_valid_i (host_valid),
      .host_wr_i    (host_wr),
      .host_ch_i    (host_ch),
      .host_data_i  (host_data),
      .freq_valid_i (freq_valid),
      .freq_ch_i    (freq_ch),
      .freq_data_i  (freq_data),
      .host_ready_o (host_ready),
      .freq_ready_o (freq_ready),
      .accept_o     (accept_w),
      .sel_ch_o     (sel_ch_w),
      .sel_wr_o     (sel_wr_w),
      .sel_data_o   (sel_data_w)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      ch_d    = ch_q;
      wr_d    = wr_q;
      shift_d = shift_q;
      cap_d   = cap_q;
      case (state_q)
         ST_IDLE: if (accept_w) begin
            ch_d    = sel_ch_w;
            wr_d    = sel_wr_w;
            shift_d = sel_data_w;
            cnt_d   = '0;
            byte_d  = '0;
            state_d = ST_LO;
         end
         ST_LO: if (cnt_q == c_cw'(HALF - 1)) begin
            cnt_d   = '0;
            state_d = ST_HI;
         end else cnt_d = cnt_q + 1'b1;
         ST_HI: if (cnt_q == c_cw'(HALF - 1)) begin
            cnt_d = '0;
            if (!wr_q) cap_d = c_dw'({cap_q, dds_din});
            if (byte_q == c_bw'(BYTES - 1)) begin
               byte_d  = '0;
               state_d = wr_q ? ST_IOUP : ST_GAP;
            end else begin
               byte_d  = byte_q + 1'b1;
               shift_d = shift_q << 8;
               state_d = ST_LO;
            end
         end else cnt_d = cnt_q + 1'b1;
         ST_IOUP: if (cnt_q == c_cw'(IOUP_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_GAP;
         end else cnt_d = cnt_q + 1'b1;
         ST_GAP: if (cnt_q == c_cw'(CS_GAP - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end else cnt_d = cnt_q + 1'b1;
         default: state_d = ST_IDLE;
      endcase
   end

   // An out-of-range channel matches no bit, so every chip select stays high.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_csn
      assign hit_w[gi] = (ch_d == CH_W'(gi));
   end

   // Pin values follow the next state so they line up with it once registered.
   always_comb begin
      csn_d  = '1;
      pclk_d = 1'b0;
      rwn_d  = 1'b0;
      rden_d = 1'b0;
      ioup_d = 1'b0;
      dout_d = 8'h00;
      if (state_d == ST_LO || state_d == ST_HI) begin
         csn_d  = ~hit_w;
         pclk_d = (state_d == ST_HI);
         rwn_d  = ~wr_d;
         rden_d = ~wr_d;
         if (wr_d) dout_d = shift_d[c_dw-1 -: 8];
      end else if (state_d == ST_IOUP) begin
         ioup_d = 1'b1;
      end
      rsp_valid_d = (state_q == ST_HI) && (state_d == ST_GAP);
      rsp_data_d  = rsp_valid_d ? cap_d : rsp_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         byte_q      <= '0;
         ch_q        <= '0;
         wr_q        <= 1'b0;
         shift_q     <= '0;
         cap_q       <= '0;
         csn_q       <= '1;
         pclk_q      <= 1'b0;
         rwn_q       <= 1'b0;
         rden_q      <= 1'b0;
         ioup_q      <= 1'b0;
         dout_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         byte_q      <= byte_d;
         ch_q        <= ch_d;
         wr_q        <= wr_d;
         shift_q     <= shift_d;
         cap_q       <= cap_d;
         csn_q       <= csn_d;
         pclk_q      <= pclk_d;
         rwn_q       <= rwn_d;
         rden_q      <= rden_d;
         ioup_q      <= ioup_d;
         dout_q      <= dout_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign dds_csn     = csn_q;
   assign dds_pclk    = pclk_q;
   assign dds_rwn     = rwn_q;
   assign dds_read_en = rden_q;
   assign dds_ioup    = ioup_q;
   assign dds_dout    = dout_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_par_engine.sv
// ============================================================================
// Module      : tb_dds_par_engine
// Description : Self-checking bench for dds_par_engine (default, swept and
//               illegal-channel configurations) against a cycle-index model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_par_engine;

   typedef struct packed {
      logic [3:0]  csn;
      logic        pclk;
      logic        rwn;
      logic        rden;
      logic        ioup;
      logic [7:0]  dout;
      logic        busy;
      logic        hr;
      logic        rv;
      logic [31:0] rd;
   } obs_t;

   // Instance 0: defaults; 1: NUM_CH=4,BYTES=2,HALF=1,IOUP=1,GAP=1; 2: NUM_CH=2,CH_W=2.
   localparam int NCH_P   [3] = '{2, 4, 2};
   localparam int BYTES_P [3] = '{4, 2, 4};
   localparam int HALF_P  [3] = '{2, 1, 2};
   localparam int IOUP_P  [3] = '{2, 1, 2};
   localparam int GAP_P   [3] = '{3, 1, 3};

   logic        clk = 1'b0;
   logic        rst;
   logic        hv [3], hw [3], fv [3];
   logic [1:0]  hch [3], fch [3];
   logic [31:0] hd [3], fd [3];
   logic [7:0]  din [3];
   logic        fr [3];
   obs_t        obs [3];
   logic [31:0] last_rd [3];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   logic        a_hr, a_fr, a_rv, a_busy, a_pclk, a_rwn, a_rden, a_ioup;
   logic [31:0] a_rd;
   logic [1:0]  a_csn;
   logic [7:0]  a_dout;
   logic        b_hr, b_fr, b_rv, b_busy, b_pclk, b_rwn, b_rden, b_ioup;
   logic [15:0] b_rd;
   logic [3:0]  b_csn;
   logic [7:0]  b_dout;
   logic        c_hr, c_fr, c_rv, c_busy, c_pclk, c_rwn, c_rden, c_ioup;
   logic [31:0] c_rd;
   logic [1:0]  c_csn;
   logic [7:0]  c_dout;

   dds_par_engine u_a (
      .clk(clk), .rst(rst),
      .host_valid(hv[0]), .host_ready(a_hr), .host_wr(hw[0]), .host_ch(hch[0][0:0]),
      .host_data(hd[0]), .rsp_valid(a_rv), .rsp_data(a_rd),
      .freq_valid(fv[0]), .freq_ready(a_fr), .freq_ch(fch[0][0:0]), .freq_data(fd[0]),
      .busy(a_busy), .dds_pclk(a_pclk), .dds_csn(a_csn), .dds_rwn(a_rwn),
      .dds_read_en(a_rden), .dds_ioup(a_ioup), .dds_dout(a_dout), .dds_din(din[0])
   );

   dds_par_engine #(.NUM_CH(4), .BYTES(2), .HALF(1), .IOUP_LEN(1), .CS_GAP(1)) u_b (
      .clk(clk), .rst(rst),
      .host_valid(hv[1]), .host_ready(b_hr), .host_wr(hw[1]), .host_ch(hch[1]),
      .host_data(hd[1][15:0]), .rsp_valid(b_rv), .rsp_data(b_rd),
      .freq_valid(fv[1]), .freq_ready(b_fr), .freq_ch(fch[1]), .freq_data(fd[1][15:0]),
      .busy(b_busy), .dds_pclk(b_pclk), .dds_csn(b_csn), .dds_rwn(b_rwn),
      .dds_read_en(b_rden), .dds_ioup(b_ioup), .dds_dout(b_dout), .dds_din(din[1])
   );

   dds_par_engine #(.NUM_CH(2), .CH_W(2)) u_c (
      .clk(clk), .rst(rst),
      .host_valid(hv[2]), .host_ready(c_hr), .host_wr(hw[2]), .host_ch(hch[2]),
      .host_data(hd[2]), .rsp_valid(c_rv), .rsp_data(c_rd),
      .freq_valid(fv[2]), .freq_ready(c_fr), .freq_ch(fch[2]), .freq_data(fd[2]),
      .busy(c_busy), .dds_pclk(c_pclk), .dds_csn(c_csn), .dds_rwn(c_rwn),
      .dds_read_en(c_rden), .dds_ioup(c_ioup), .dds_dout(c_dout), .dds_din(din[2])
   );

   assign obs[0] = {2'b11, a_csn, a_pclk, a_rwn, a_rden, a_ioup, a_dout, a_busy, a_hr, a_rv, a_rd};
   assign obs[1] = {b_csn, b_pclk, b_rwn, b_rden, b_ioup, b_dout, b_busy, b_hr, b_rv, 16'h0, b_rd};
   assign obs[2] = {2'b11, c_csn, c_pclk, c_rwn, c_rden, c_ioup, c_dout, c_busy, c_hr, c_rv, c_rd};
   assign fr[0]  = a_fr;
   assign fr[1]  = b_fr;
   assign fr[2]  = c_fr;

   function automatic int nfr(input int i);
      return 2 * HALF_P[i] * BYTES_P[i];
   endfunction

   function automatic int flen(input int i, input bit wr);
      return 1 + nfr(i) + (wr ? IOUP_P[i] : 0) + GAP_P[i];
   endfunction

   // Expected pins k cycles after the accept cycle, straight from the frame rules.
   function automatic obs_t model(input int i, input int k, input logic [1:0] ch, input bit wr,
                                  input logic [31:0] data, input logic [31:0] dinv,
                                  input logic [31:0] prev);
      obs_t e;
      int   nf, g0, len, b;
      nf  = nfr(i);
      g0  = 1 + nf + (wr ? IOUP_P[i] : 0);
      len = g0 + GAP_P[i];
      e      = '0;
      e.csn  = 4'hF;
      e.rd   = prev;
      e.busy = (k >= 1) && (k < len);
      e.hr   = (k >= len);
      if (k >= 1 && k <= nf) begin
         b      = (k - 1) / (2 * HALF_P[i]);
         e.pclk = ((k - 1) % (2 * HALF_P[i])) >= HALF_P[i];
         if (int'(ch) < NCH_P[i]) e.csn[ch] = 1'b0;
         e.rwn  = !wr;
         e.rden = !wr;
         if (wr) e.dout = 8'(data >> (8 * (BYTES_P[i] - 1 - b)));
      end else if (k > nf && k < g0) begin
         e.ioup = 1'b1;
      end
      if (!wr && k >= g0) begin
         e.rd = dinv;
         e.rv = (k == g0);
      end
      return e;
   endfunction

   task automatic check(input string tag, input int k, input obs_t o, input obs_t e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
      end
   endtask

   task automatic check1(input string tag, input logic o, input logic e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // Called at a negedge; leaves the request up and confirms it will be accepted.
   task automatic start(input int i, input bit src, input logic [1:0] ch, input bit wr,
                        input logic [31:0] data);
      if (src) begin
         fv[i] = 1'b1; fch[i] = ch; fd[i] = data;
      end else begin
         hv[i] = 1'b1; hw[i] = wr; hch[i] = ch; hd[i] = data;
      end
      #1;
      for (int t = 0; t < 60; t++) begin
         if (src ? fr[i] : obs[i].hr) break;
         @(negedge clk); #1;
      end
      check1(src ? "freq_accept" : "host_accept", src ? fr[i] : obs[i].hr, 1'b1);
   endtask

   // Follows one frame from its accept edge until the next accept-capable cycle.
   task automatic track(input int i, input string tag, input logic [1:0] ch, input bit wr,
                        input logic [31:0] data, input logic [31:0] dinv, input bit hold_host);
      int len, nf;
      len = flen(i, wr);
      nf  = nfr(i);
      @(posedge clk); #1;
      fv[i] = 1'b0;
      if (!hold_host) hv[i] = 1'b0;
      for (int k = 1; k <= len; k++) begin
         din[i] = (k <= nf) ? 8'(dinv >> (8 * (BYTES_P[i] - 1 - (k - 1) / (2 * HALF_P[i]))))
                            : 8'h00;
         @(negedge clk);
         check(tag, k, obs[i], model(i, k, ch, wr, data, dinv, last_rd[i]));
         if (k < len) begin
            @(posedge clk); #1;
         end
      end
      if (!wr) last_rd[i] = dinv;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0]  rch;
      bit          rwr;
      logic [31:0] rdata, rdin;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         hv[i] = 1'b0; hw[i] = 1'b0; hch[i] = 2'd0; hd[i] = '0;
         fv[i] = 1'b0; fch[i] = 2'd0; fd[i] = '0; din[i] = 8'h00; last_rd[i] = '0;
      end
      fv[0] = 1'b1;
      hv[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check("reset_state", 0, obs[i], model(i, 0, 2'd0, 1'b1, '0, '0, '0));
      check1("reset_freq_ready", fr[0], 1'b0);
      fv[0] = 1'b0;
      hv[1] = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      start(0, 1'b0, 2'd1, 1'b1, 32'h0A1B2C3D);
      track(0, "host_write_ch1", 2'd1, 1'b1, 32'h0A1B2C3D, '0, 1'b0);

      start(0, 1'b0, 2'd0, 1'b0, '0);
      track(0, "host_read_ch0", 2'd0, 1'b0, '0, 32'h11223344, 1'b0);

      hv[0] = 1'b1; hw[0] = 1'b1; hch[0] = 2'd0; hd[0] = 32'hCAFEF00D;
      start(0, 1'b1, 2'd1, 1'b1, 32'h12345678);
      check1("both_valid_host_ready", obs[0].hr, 1'b0);
      track(0, "stream_first", 2'd1, 1'b1, 32'h12345678, '0, 1'b1);
      track(0, "host_after_stream", 2'd0, 1'b1, 32'hCAFEF00D, '0, 1'b0);

      // Reset during the second HI cycle of byte 2 of a read.
      start(0, 1'b0, 2'd1, 1'b0, '0);
      @(posedge clk); #1;
      hv[0] = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check1("rst_host_ready", obs[0].hr, 1'b0);
      check1("busy_before_rst_edge", obs[0].busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      last_rd[0] = '0;
      check("after_reset", 0, obs[0], model(0, flen(0, 1'b1), 2'd0, 1'b1, '0, '0, '0));
      for (int t = 0; t < 25; t++) begin
         @(negedge clk);
         check1("no_rsp_after_abort", obs[0].rv, 1'b0);
      end
      start(0, 1'b0, 2'd0, 1'b1, 32'h5AA5C33C);
      track(0, "write_after_reset", 2'd0, 1'b1, 32'h5AA5C33C, '0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         rch   = 2'($urandom_range(0, 1));
         rwr   = 1'($urandom_range(0, 1));
         rdata = $urandom;
         rdin  = $urandom;
         start(0, 1'b0, rch, rwr, rdata);
         track(0, "random_default", rch, rwr, rdata, rdin, 1'b0);
      end

      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         rdata = $urandom & 32'h0000FFFF;
         start(1, 1'b1, 2'(c), 1'b1, rdata);
         track(1, "sweep_stream", 2'(c), 1'b1, rdata, '0, 1'b0);
      end
      rdin = $urandom & 32'h0000FFFF;
      start(1, 1'b0, 2'd3, 1'b0, '0);
      track(1, "sweep_read", 2'd3, 1'b0, '0, rdin, 1'b0);

      @(negedge clk);
      start(2, 1'b0, 2'd2, 1'b1, 32'hDEADBEEF);
      track(2, "illegal_ch_write", 2'd2, 1'b1, 32'hDEADBEEF, '0, 1'b0);
      start(2, 1'b0, 2'd3, 1'b0, '0);
      track(2, "illegal_ch_read", 2'd3, 1'b0, '0, 32'h55667788, 1'b0);
      start(2, 1'b0, 2'd1, 1'b1, 32'h01020304);
      track(2, "legal_ch_wide", 2'd1, 1'b1, 32'h01020304, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
